// File: rtl/hps_ext_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hps_ext_pkg
//  Description : Command codes, FSM states and EXT_BUS bit map for the
//                HPS EXT_BUS command bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package hps_ext_pkg;

    localparam logic [15:0] CD_STATS = 16'h0033;
    localparam logic [15:0] CD_GET   = 16'h0034;
    localparam logic [15:0] CD_SET   = 16'h0035;
    localparam logic [15:0] CD_DATA  = 16'h0036;

    localparam int c_EXT_DOUT_LSB = 0;
    localparam int c_EXT_DIN_LSB  = 16;
    localparam int c_EXT_WAIT     = 32;
    localparam int c_EXT_STROBE   = 33;
    localparam int c_EXT_ENABLE   = 34;
    localparam int c_EXT_SPARE    = 35;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STATS  = 3'd1,
        ST_GET    = 3'd2,
        ST_SET    = 3'd3,
        ST_DATA   = 3'd4,
        ST_IGNORE = 3'd5
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hps_ext_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : hps_ext_fifo
//  Description : Synchronous FIFO with level and almost-full flag; a push
//                into a full FIFO is accepted only when a pop frees a slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module hps_ext_fifo #(
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4,
    parameter int WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_almost_full,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [LVL_W-1:0] r_level_q, w_level_d;
    logic             w_full, w_empty, w_do_push, w_do_pop;

    assign w_full    = (r_level_q == LVL_W'(DEPTH));
    assign w_empty   = (r_level_q == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        if (w_do_push) w_wr_ptr_d = r_wr_ptr_q + PTR_W'(1);
        if (w_do_pop)  w_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
        case ({w_do_push, w_do_pop})
            2'b10:   w_level_d = r_level_q + LVL_W'(1);
            2'b01:   w_level_d = r_level_q - LVL_W'(1);
            default: w_level_d = r_level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_level_q  <= w_level_d;
        end
    end

    // Storage carries no reset; the level counter alone defines validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem_q[r_wr_ptr_q] <= i_din;
    end

    assign o_dout        = r_mem_q[r_rd_ptr_q];
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_almost_full = (r_level_q >= LVL_W'(DEPTH - AF_MARGIN));
    assign o_level       = r_level_q;

endmodule
`default_nettype wire

// File: rtl/hps_ext_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : hps_ext_bridge
//  Description : HPS EXT_BUS command bridge (STATS/GET/SET/DATA) with a
//                buffered DATA stream. Define HPS_EXT_CHECKSUM_EN to return a
//                running DATA checksum on STATS word 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module hps_ext_bridge
    import hps_ext_pkg::*;
#(
    parameter int CD_WORDS   = 7,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_MARGIN  = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    inout  wire  [35:0]           EXT_BUS,
    input  logic [16*CD_WORDS:0]  cd_in,
    output logic [16*CD_WORDS:0]  cd_out,
    output logic                  cd_en,
    output logic [15:0]           data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  data_download,
    input  logic                  audio_almost_full
);

    localparam int REC_W = 16 * CD_WORDS + 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]      w_io_din;
    logic             w_io_strobe, w_io_enable;

    state_e           r_state_q, w_state_d;
    logic [15:0]      r_byte_cnt_q, w_byte_cnt_d;
    logic [15:0]      r_io_dout_q, w_io_dout_d;
    logic [REC_W-1:0] r_cd_out_q, w_cd_out_d;
    logic             r_cd_en_q, w_cd_en_d;
    logic             r_data_download_q, w_data_download_d;
    logic             r_overflow_q, w_overflow_d;
    logic [7:0]       r_req_cnt_q, w_req_cnt_d;
    logic             r_cd_msb_q, w_cd_msb_d;

    logic             w_push, w_pop, w_data_start;
    logic             w_fifo_full, w_fifo_empty, w_fifo_af;
    logic [LVL_W-1:0] w_fifo_level;
    logic [15:0]      w_stats_word2;
    logic             w_unused_bus;

    assign w_io_din     = EXT_BUS[c_EXT_DIN_LSB +: 16];
    assign w_io_strobe  = EXT_BUS[c_EXT_STROBE];
    assign w_io_enable  = EXT_BUS[c_EXT_ENABLE];
    assign w_unused_bus = EXT_BUS[c_EXT_SPARE];

    assign w_pop = data_ready & ~w_fifo_empty;

    always_comb begin
        w_cd_msb_d  = cd_in[REC_W-1];
        w_req_cnt_d = r_req_cnt_q;
        if (w_cd_msb_d != r_cd_msb_q) w_req_cnt_d = r_req_cnt_q + 8'd1;
    end

    always_comb begin
        w_state_d         = r_state_q;
        w_byte_cnt_d      = r_byte_cnt_q;
        w_io_dout_d       = r_io_dout_q;
        w_cd_out_d        = r_cd_out_q;
        w_cd_en_d         = r_cd_en_q;
        w_data_download_d = r_data_download_q;
        w_overflow_d      = r_overflow_q;
        w_push            = 1'b0;
        w_data_start      = 1'b0;

        if (!w_io_enable) begin
            w_state_d         = ST_IDLE;
            w_byte_cnt_d      = '0;
            w_io_dout_d       = '0;
            w_data_download_d = 1'b0;
            // The record-complete flag flips only on the cycle SET closes.
            if (r_state_q == ST_SET) w_cd_out_d[REC_W-1] = ~r_cd_out_q[REC_W-1];
        end else if (w_io_strobe) begin
            w_io_dout_d  = '0;
            w_byte_cnt_d = sat_inc16(r_byte_cnt_q);
            case (r_state_q)
                ST_IDLE: begin
                    case (w_io_din)
                        CD_STATS: w_state_d = ST_STATS;
                        CD_GET: begin
                            w_state_d   = ST_GET;
                            w_io_dout_d = {8'h00, r_req_cnt_q};
                        end
                        CD_SET:   w_state_d = ST_SET;
                        CD_DATA: begin
                            w_state_d         = ST_DATA;
                            w_data_download_d = 1'b1;
                            w_data_start      = 1'b1;
                        end
                        default:  w_state_d = ST_IGNORE;
                    endcase
                end
                ST_STATS: begin
                    if (r_byte_cnt_q == 16'd1) begin
                        w_cd_en_d    = w_io_din[0];
                        w_io_dout_d  = {r_overflow_q, 15'(w_fifo_level)};
                        w_overflow_d = 1'b0;
                    end else if (r_byte_cnt_q == 16'd2) begin
                        w_io_dout_d = w_stats_word2;
                    end
                end
                ST_GET: begin
                    for (int k = 1; k <= CD_WORDS; k++) begin
                        if (r_byte_cnt_q == 16'(k)) w_io_dout_d = cd_in[16*k-1 -: 16];
                    end
                end
                ST_SET: begin
                    for (int k = 1; k <= CD_WORDS; k++) begin
                        if (r_byte_cnt_q == 16'(k)) w_cd_out_d[16*k-1 -: 16] = w_io_din;
                    end
                end
                ST_DATA:  w_push = 1'b1;
                default:  ;
            endcase
        end

        if (w_push && w_fifo_full && !w_pop) w_overflow_d = 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state_q         <= ST_IDLE;
            r_byte_cnt_q      <= '0;
            r_io_dout_q       <= '0;
            r_cd_out_q        <= '0;
            r_cd_en_q         <= 1'b0;
            r_data_download_q <= 1'b0;
            r_overflow_q      <= 1'b0;
            r_req_cnt_q       <= '0;
            r_cd_msb_q        <= cd_in[REC_W-1];
        end else begin
            r_state_q         <= w_state_d;
            r_byte_cnt_q      <= w_byte_cnt_d;
            r_io_dout_q       <= w_io_dout_d;
            r_cd_out_q        <= w_cd_out_d;
            r_cd_en_q         <= w_cd_en_d;
            r_data_download_q <= w_data_download_d;
            r_overflow_q      <= w_overflow_d;
            r_req_cnt_q       <= w_req_cnt_d;
            r_cd_msb_q        <= w_cd_msb_d;
        end
    end

`ifdef HPS_EXT_CHECKSUM_EN
    logic [15:0] r_csum_q, w_csum_d;
    logic        w_push_acc;

    assign w_push_acc = w_push & (~w_fifo_full | w_pop);

    always_comb begin
        w_csum_d = r_csum_q;
        if (w_data_start)    w_csum_d = '0;
        else if (w_push_acc) w_csum_d = r_csum_q + w_io_din;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) r_csum_q <= '0;
        else          r_csum_q <= w_csum_d;
    end

    assign w_stats_word2 = r_csum_q;
`else
    logic w_unused_csum;
    assign w_unused_csum = w_data_start;
    assign w_stats_word2 = '0;
`endif

    hps_ext_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .AF_MARGIN (AF_MARGIN),
        .WIDTH     (16)
    ) u_fifo (
        .clk           (clk_sys),
        .rst_n         (reset_n),
        .i_push        (w_push),
        .i_din         (w_io_din),
        .i_pop         (w_pop),
        .o_dout        (data_out),
        .o_full        (w_fifo_full),
        .o_empty       (w_fifo_empty),
        .o_almost_full (w_fifo_af),
        .o_level       (w_fifo_level)
    );

    assign EXT_BUS[c_EXT_DOUT_LSB +: 16] = r_io_dout_q;
    assign EXT_BUS[c_EXT_WAIT] = audio_almost_full | w_fifo_af | (w_io_enable & w_io_strobe);

    assign cd_out        = r_cd_out_q;
    assign cd_en         = r_cd_en_q;
    assign data_valid    = ~w_fifo_empty;
    assign data_download = r_data_download_q;

endmodule
`default_nettype wire

// File: tb/tb_hps_ext_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hps_ext_bridge
//  Description : Self-checking bench for hps_ext_bridge with a queue-based
//                reference model of the command records and DATA stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hps_ext_bridge;

    localparam int CD_WORDS   = 7;
    localparam int FIFO_DEPTH = 16;
    localparam int AF_MARGIN  = 4;
    localparam int REC_W      = 16 * CD_WORDS + 1;

    logic             clk_sys = 1'b0;
    logic             reset_n = 1'b0;
    wire  [35:0]      ext_bus;
    logic [15:0]      io_din = '0;
    logic             io_strobe = 1'b0;
    logic             io_enable = 1'b0;
    logic [REC_W-1:0] cd_in = '0;
    wire  [REC_W-1:0] cd_out;
    wire              cd_en;
    wire  [15:0]      data_out;
    wire              data_valid;
    logic             data_ready = 1'b0;
    wire              data_download;
    logic             audio_almost_full = 1'b0;

    assign ext_bus[31:16] = io_din;
    assign ext_bus[33]    = io_strobe;
    assign ext_bus[34]    = io_enable;
    assign ext_bus[35]    = 1'b0;

    int               checks = 0;
    int               errors = 0;
    logic [15:0]      popq [$];
    logic [15:0]      mq [$];
    logic [REC_W-1:0] exp_rec = '0;
    logic [7:0]       exp_req = '0;
    logic [15:0]      gw [0:CD_WORDS];

    hps_ext_bridge #(
        .CD_WORDS   (CD_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .AF_MARGIN  (AF_MARGIN)
    ) dut (
        .clk_sys           (clk_sys),
        .reset_n           (reset_n),
        .EXT_BUS           (ext_bus),
        .cd_in             (cd_in),
        .cd_out            (cd_out),
        .cd_en             (cd_en),
        .data_out          (data_out),
        .data_valid        (data_valid),
        .data_ready        (data_ready),
        .data_download     (data_download),
        .audio_almost_full (audio_almost_full)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (reset_n && data_valid && data_ready) popq.push_back(data_out);
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic bus_word(input logic [15:0] din, output logic [15:0] dout);
        io_enable = 1'b1;
        io_din    = din;
        io_strobe = 1'b1;
        tick();
        io_strobe = 1'b0;
        dout      = ext_bus[15:0];
    endtask

    task automatic end_txn();
        io_enable = 1'b0;
        io_strobe = 1'b0;
        tick();
        tick();
    endtask

    task automatic drain(output bit done);
        data_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 4 * FIFO_DEPTH; i++) begin
            if (!data_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        data_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset_n = 1'b0;
        repeat (3) tick();
        checks++; if (cd_out !== '0) begin errors++; $display("FAIL reset_cd_out got %h want 0", cd_out); end
        checks++; if (cd_en !== 1'b0) begin errors++; $display("FAIL reset_cd_en got %b want 0", cd_en); end
        checks++; if (ext_bus[15:0] !== 16'h0) begin errors++; $display("FAIL reset_io_dout got %h want 0", ext_bus[15:0]); end
        checks++; if (data_download !== 1'b0) begin errors++; $display("FAIL reset_download got %b want 0", data_download); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", data_valid); end
        checks++; if (ext_bus[32] !== 1'b0) begin errors++; $display("FAIL reset_wait got %b want 0", ext_bus[32]); end
        reset_n = 1'b1;
        tick();
        audio_almost_full = 1'b1;
        #1;
        checks++; if (ext_bus[32] !== 1'b1) begin errors++; $display("FAIL audio_af_wait got %b want 1", ext_bus[32]); end
        audio_almost_full = 1'b0;
        tick();
        bus_word(16'h0034, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_req_cnt got %h want 0000", d); end
        end_txn();
    endtask

    task automatic test_get();
        logic [15:0] d, want;
        int n;
        for (int k = 1; k <= CD_WORDS; k++) begin
            gw[k] = 16'(16'h1111 * k);
            cd_in[16*k-1 -: 16] = gw[k];
        end
        for (int round = 0; round < 3; round++) begin
            n = (round == 0) ? 3 : $urandom_range(1, 6);
            for (int t = 0; t < n; t++) begin
                cd_in[REC_W-1] = ~cd_in[REC_W-1];
                repeat ($urandom_range(1, 3)) tick();
            end
            exp_req = exp_req + 8'(n);
            bus_word(16'h0034, d);
            checks++; if (d !== {8'h00, exp_req}) begin errors++; $display("FAIL get_word0 got %h want %h", d, {8'h00, exp_req}); end
            for (int k = 1; k <= CD_WORDS + 2; k++) begin
                bus_word(16'($urandom), d);
                if (k <= CD_WORDS) want = gw[k]; else want = 16'h0000;
                checks++; if (d !== want) begin errors++; $display("FAIL get_word%0d got %h want %h", k, d, want); end
            end
            end_txn();
            for (int k = 1; k <= CD_WORDS; k++) begin
                gw[k] = 16'($urandom);
                cd_in[16*k-1 -: 16] = gw[k];
            end
        end
    endtask

    task automatic test_set();
        logic [15:0] d, w;
        bus_word(16'h0035, d);
        for (int k = 1; k <= CD_WORDS; k++) begin
            w = 16'(16'hA000 + k);
            bus_word(w, d);
            exp_rec[16*k-1 -: 16] = w;
            checks++; if (d !== 16'h0) begin errors++; $display("FAIL set_read%0d got %h want 0000", k, d); end
        end
        end_txn();
        exp_rec[REC_W-1] = ~exp_rec[REC_W-1];
        checks++; if (cd_out !== exp_rec) begin errors++; $display("FAIL set_record got %h want %h", cd_out, exp_rec); end
        bus_word(16'h0099, d);
        checks++; if (d !== 16'h0) begin errors++; $display("FAIL ignore_word0 got %h want 0000", d); end
        for (int k = 1; k <= 3; k++) begin
            bus_word(16'($urandom), d);
            checks++; if (d !== 16'h0) begin errors++; $display("FAIL ignore_word%0d got %h want 0000", k, d); end
        end
        end_txn();
        checks++; if (cd_out !== exp_rec) begin errors++; $display("FAIL ignore_record got %h want %h", cd_out, exp_rec); end
        bus_word(16'h0035, d);
        for (int k = 1; k <= CD_WORDS + 2; k++) begin
            w = 16'($urandom);
            bus_word(w, d);
            if (k <= CD_WORDS) exp_rec[16*k-1 -: 16] = w;
        end
        end_txn();
        exp_rec[REC_W-1] = ~exp_rec[REC_W-1];
        checks++; if (cd_out !== exp_rec) begin errors++; $display("FAIL set_rand_record got %h want %h", cd_out, exp_rec); end
    endtask

    task automatic test_overflow();
        logic [15:0] d, w;
        logic        want_wait;
        int          drops;
        bit          done;
        drops = 0;
        mq.delete();
        data_ready = 1'b0;
        bus_word(16'h0036, d);
        checks++; if (data_download !== 1'b1) begin errors++; $display("FAIL download_open got %b want 1", data_download); end
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            w = 16'($urandom);
            bus_word(w, d);
            if (mq.size() < FIFO_DEPTH) mq.push_back(w); else drops++;
            #1;
            want_wait = (mq.size() >= FIFO_DEPTH - AF_MARGIN);
            checks++; if (ext_bus[32] !== want_wait) begin errors++; $display("FAIL af_wait_lvl%0d got %b want %b", mq.size(), ext_bus[32], want_wait); end
        end
        end_txn();
        checks++; if (data_download !== 1'b0) begin errors++; $display("FAIL download_close got %b want 0", data_download); end
        bus_word(16'h0033, d);
        bus_word(16'h0001, d);
        checks++; if (d !== {drops > 0, 15'(mq.size())}) begin errors++; $display("FAIL stats_ovf got %h want %h", d, {drops > 0, 15'(mq.size())}); end
        end_txn();
        checks++; if (cd_en !== 1'b1) begin errors++; $display("FAIL cd_en_set got %b want 1", cd_en); end
        bus_word(16'h0033, d);
        bus_word(16'h0001, d);
        checks++; if (d !== {1'b0, 15'(mq.size())}) begin errors++; $display("FAIL stats_ovf_clr got %h want %h", d, {1'b0, 15'(mq.size())}); end
        end_txn();
        popq.delete();
        drain(done);
        checks++; if (!done) begin errors++; $display("FAIL ovf_drain_timeout got valid %b want 0", data_valid); end
        checks++; if (popq.size() !== mq.size()) begin errors++; $display("FAIL ovf_drain_count got %0d want %0d", popq.size(), mq.size()); end
        for (int i = 0; i < mq.size() && i < popq.size(); i++) begin
            checks++; if (popq[i] !== mq[i]) begin errors++; $display("FAIL ovf_data%0d got %h want %h", i, popq[i], mq[i]); end
        end
    endtask

    task automatic test_stream();
        logic [15:0] d;
        bit          done;
        mq.delete();
        popq.delete();
        data_ready = 1'b1;
        bus_word(16'h0036, d);
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            bus_word(16'(i), d);
            mq.push_back(16'(i));
        end
        end_txn();
        drain(done);
        checks++; if (!done) begin errors++; $display("FAIL stream_drain_timeout got valid %b want 0", data_valid); end
        checks++; if (popq.size() !== mq.size()) begin errors++; $display("FAIL stream_count got %0d want %0d", popq.size(), mq.size()); end
        for (int i = 0; i < mq.size() && i < popq.size(); i++) begin
            checks++; if (popq[i] !== mq[i]) begin errors++; $display("FAIL stream_data%0d got %h want %h", i, popq[i], mq[i]); end
        end
        bus_word(16'h0033, d);
        bus_word(16'h0001, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL stream_stats got %h want 0000", d); end
        end_txn();
    endtask

    task automatic test_reset_abort();
        logic [15:0] d;
        bus_word(16'h0035, d);
        for (int k = 1; k <= 3; k++) bus_word(16'($urandom), d);
        reset_n = 1'b0;
        tick();
        checks++; if (cd_out !== '0) begin errors++; $display("FAIL abort_set_cd_out got %h want 0", cd_out); end
        checks++; if (cd_en !== 1'b0) begin errors++; $display("FAIL abort_set_cd_en got %b want 0", cd_en); end
        checks++; if (ext_bus[15:0] !== 16'h0) begin errors++; $display("FAIL abort_set_dout got %h want 0000", ext_bus[15:0]); end
        io_enable = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();
        exp_rec = '0;
        exp_req = '0;
        checks++; if (cd_out !== '0) begin errors++; $display("FAIL abort_no_toggle got %h want 0", cd_out); end
        bus_word(16'h0036, d);
        for (int k = 1; k <= 5; k++) bus_word(16'($urandom), d);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL abort_data_filled got %b want 1", data_valid); end
        reset_n = 1'b0;
        tick();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL abort_data_valid got %b want 0", data_valid); end
        checks++; if (data_download !== 1'b0) begin errors++; $display("FAIL abort_download got %b want 0", data_download); end
        io_enable = 1'b0;
        reset_n = 1'b1;
        tick();
        bus_word(16'h0033, d);
        bus_word(16'h0000, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL abort_stats got %h want 0000", d); end
        end_txn();
    endtask

    task automatic test_checksum();
        logic [15:0] d, w, sum, want;
        bit          done;
        logic [15:0] words [$];
        for (int round = 0; round < 2; round++) begin
            words.delete();
            if (round == 0) words = '{16'h0001, 16'h0002, 16'h0003, 16'hFFFF};
            else for (int i = 0; i < 3; i++) words.push_back(16'($urandom));
            sum = '0;
            data_ready = 1'b0;
            bus_word(16'h0036, d);
            foreach (words[i]) begin
                w = words[i];
                bus_word(w, d);
                sum = sum + w;
            end
            end_txn();
`ifdef HPS_EXT_CHECKSUM_EN
            want = sum;
`else
            want = 16'h0000;
`endif
            bus_word(16'h0033, d);
            bus_word(16'h0000, d);
            checks++; if (d !== 16'(words.size())) begin errors++; $display("FAIL csum_level got %h want %h", d, 16'(words.size())); end
            bus_word(16'($urandom), d);
            checks++; if (d !== want) begin errors++; $display("FAIL csum_word2_r%0d got %h want %h", round, d, want); end
            end_txn();
            popq.delete();
            drain(done);
            checks++; if (!done || popq.size() !== words.size()) begin errors++; $display("FAIL csum_drain got %0d want %0d", popq.size(), words.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_get();
        test_set();
        test_overflow();
        test_stream();
        test_reset_abort();
        test_checksum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
